pokey_pot_scan: RTL and testbench

- Paddle/pot scanner stage, directly downstream of the per-line input synchronizers in the POKEY core.
- Consumes the eight already-synchronized pot comparator lines and runs a scan counter paced by the 15 kHz tick, or by every ce in fast-scan mode.
- Latches the count at which each line crosses threshold into a per-pot value, and drives the capacitor dump control.
- Exposes POT0-7 and ALLPOT to the register read mux.

---
 rtl/pokey_pot_scan.sv | 94 +++++++++
 tb/tb_pokey_pot_scan.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pokey_pot_scan.sv
// POKEY paddle/pot scan stage: counts scan ticks and latches per-pot crossings.
// Optional POT_CLEAR_ON_GO_EN clears pot_vals whenever a potgo is accepted.
module pokey_pot_scan #(
    parameter int MAX_COUNT = 228,
    parameter int NUM_POTS  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        en_15k,
    input  logic        fast_scan,
    input  logic        potgo,
    input  logic [7:0]  pot_in,
    output logic        pot_dump,
    output logic [63:0] pot_vals,
    output logic [7:0]  allpot,
    output logic        busy
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [7:0] MAX = 8'(MAX_COUNT);

    state_t      state, state_n;
    logic [7:0]  count, count_n;
    logic [7:0]  allpot_n;
    logic [63:0] vals_n;
    logic        tick, go;

    assign tick = ce & (fast_scan | en_15k);
    assign go   = ce & potgo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            allpot   <= '0;
            pot_vals <= '0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            allpot   <= allpot_n;
            pot_vals <= vals_n;
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        allpot_n = allpot;
        vals_n   = pot_vals;
        unique case (state)
            IDLE: begin
                allpot_n = '0;
                if (go) begin
                    state_n  = COUNT;
                    count_n  = '0;
                    allpot_n = '1;
`ifdef POT_CLEAR_ON_GO_EN
                    vals_n   = '0;
`endif
                end
            end
            COUNT: begin
                // A restart strobe overrides any latch on the same tick
                if (go) begin
                    count_n  = '0;
                    allpot_n = '1;
`ifdef POT_CLEAR_ON_GO_EN
                    vals_n   = '0;
`endif
                end else if (tick) begin
                    for (int n = 0; n < NUM_POTS; n++) begin
                        if (allpot[n] && (pot_in[n] || count == MAX)) begin
                            vals_n[8*n +: 8] = count;
                            allpot_n[n]      = 1'b0;
                        end
                    end
                    if (count == MAX) begin
                        allpot_n = '0;
                        state_n  = IDLE;
                    end else begin
                        count_n = count + 8'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign pot_dump = (state == IDLE);
    assign busy     = (state == COUNT);

endmodule

// File: tb/tb_pokey_pot_scan.sv
// Directed testbench for pokey_pot_scan.
// Runs with or without POT_CLEAR_ON_GO_EN defined.
module tb_pokey_pot_scan;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce, en_15k, fast_scan, potgo;
    logic [7:0]  pot_in;
    logic        pot_dump, busy;
    logic [63:0] pot_vals;
    logic [7:0]  allpot;

    int n_run  = 0;
    int n_fail = 0;

    pokey_pot_scan dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .en_15k    (en_15k),
        .fast_scan (fast_scan),
        .potgo     (potgo),
        .pot_in    (pot_in),
        .pot_dump  (pot_dump),
        .pot_vals  (pot_vals),
        .allpot    (allpot),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // 113 idle ce followed by one en_15k tick
    task automatic tick15();
        step(113);
        en_15k = 1'b1;
        step(1);
        en_15k = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        ce        = 1'b1;
        en_15k    = 1'b0;
        fast_scan = 1'b1;
        potgo     = 1'b0;
        pot_in    = 8'h00;
        #12;
        check("rst_vals", pot_vals, 64'h0);
        check("rst_allpot", allpot, 8'h00);
        check("rst_dump", pot_dump, 1'b1);
        check("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        step(2);
        check("idle_busy", busy, 1'b0);

        // Fast scan, pot 3 crosses at count 50
        potgo = 1'b1;
        step(1);
        potgo = 1'b0;
        check("go_allpot", allpot, 8'hFF);
        check("go_dump", pot_dump, 1'b0);
        check("go_busy", busy, 1'b1);
        step(50);
        pot_in[3] = 1'b1;
        step(1);
        check("p3_val", pot_vals[31:24], 8'd50);
        check("p3_allpot", allpot, 8'hF7);
        step(177);
        check("pre_end_busy", busy, 1'b1);
        check("pre_end_allpot", allpot, 8'hF7);
        step(1);
        check("end_vals", pot_vals, 64'hE4E4E4E4_32E4E4E4);
        check("end_allpot", allpot, 8'h00);
        check("end_dump", pot_dump, 1'b1);
        check("end_busy", busy, 1'b0);

        // Slow scan with every line already high
        fast_scan = 1'b0;
        pot_in    = 8'hFF;
        potgo     = 1'b1;
        step(1);
        potgo = 1'b0;
        check("slow_busy0", busy, 1'b1);
        step(5);
        check("slow_noadv", allpot, 8'hFF);
        tick15();
        check("slow_vals0", pot_vals, 64'h0);
        check("slow_allpot0", allpot, 8'h00);
        check("slow_dump", pot_dump, 1'b0);
        for (int i = 0; i < 227; i++) tick15();
        step(113);
        check("slow_busy_228", busy, 1'b1);
        en_15k = 1'b1;
        step(1);
        en_15k = 1'b0;
        check("slow_done", busy, 1'b0);
        check("slow_done_dump", pot_dump, 1'b1);

        // Restart at count 100 with pot 0 rising on the same tick
        fast_scan = 1'b1;
        pot_in    = 8'h00;
        potgo     = 1'b1;
        en_15k    = 1'b1;
        step(1);
        potgo  = 1'b0;
        en_15k = 1'b0;
        step(100);
        potgo     = 1'b1;
        pot_in[0] = 1'b1;
        step(1);
        potgo     = 1'b0;
        pot_in[0] = 1'b0;
`ifdef POT_CLEAR_ON_GO_EN
        check("rs_nolatch", pot_vals, 64'h0);
`else
        check("rs_nolatch", pot_vals[7:0], 8'h00);
`endif
        check("rs_allpot", allpot, 8'hFF);
        step(10);
        pot_in[0] = 1'b1;
        step(1);
        check("rs_p0", pot_vals[7:0], 8'd10);
        check("rs_allpot2", allpot, 8'hFE);
        pot_in = 8'h00;

        // Async reset at count 77
        step(66);
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_vals", pot_vals, 64'h0);
        check("ar_allpot", allpot, 8'h00);
        check("ar_dump", pot_dump, 1'b1);
        check("ar_busy", busy, 1'b0);
        step(1);
        #2;
        reset_n = 1'b1;
        step(2);
        check("ar_idle", busy, 1'b0);

        // ce gating mid-scan
        potgo = 1'b1;
        step(1);
        potgo = 1'b0;
        step(5);
        pot_in[1] = 1'b1;
        step(1);
        pot_in[1] = 1'b0;
        check("ce_p1", pot_vals[15:8], 8'd5);
        ce     = 1'b0;
        potgo  = 1'b1;
        en_15k = 1'b1;
        pot_in = 8'hFF;
        step(20);
        check("ce_allpot", allpot, 8'hFD);
        check("ce_vals", pot_vals, 64'h0000_0000_0000_0500);
        check("ce_busy", busy, 1'b1);
        ce        = 1'b1;
        potgo     = 1'b0;
        en_15k    = 1'b0;
        pot_in    = 8'h04;
        step(1);
        pot_in = 8'h00;
        check("ce_p2", pot_vals[23:16], 8'd6);
        step(222);
        check("ce_end_busy", busy, 1'b0);
        check("ce_end_vals", pot_vals, 64'hE4E4E4E4_E40605E4);

        potgo = 1'b1;
        step(1);
        potgo = 1'b0;
`ifdef POT_CLEAR_ON_GO_EN
        check("go_clear", pot_vals, 64'h0);
`else
        check("go_keep", pot_vals, 64'hE4E4E4E4_E40605E4);
`endif
        check("go2_allpot", allpot, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
